regfile_valid_nr_1w: RTL and testbench

- Parametrised successor of the wavepool's fixed 40-entry, 35-bit, 1-read/1-write register file.
- Generalised in depth, width and read-port count; adds per-entry valid bits, single-entry invalidate, global flush, registered reads with write-first bypass, and a live valid count.
- Sits in the wavepool and instruction buffers, where entries are written at fetch and retired or invalidated on wavefront completion or halt.

---
 rtl/regfile_valid_nr_1w_pkg.sv | 19 +
 rtl/regfile_valid_entry.sv | 36 +++
 rtl/regfile_valid_nr_1w.sv | 138 +++++++++++++
 tb/tb_regfile_valid_nr_1w.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_valid_nr_1w_pkg.sv
// Shared constants and helpers for the valid-tracked register file.
package regfile_valid_nr_1w_pkg;

    localparam int unsigned REGFILE_DEPTH  = 40;
    localparam int unsigned REGFILE_WIDTH  = 35;
    localparam int unsigned REGFILE_ADDR_W = 6;
    localparam int unsigned REGFILE_NUM_RD = 2;

    // Number of set bits in a vector of up to 64 bits.
    function automatic int unsigned popcount64(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_valid_entry.sv
// One register-file entry: data register plus valid flop.
module regfile_valid_entry
    import regfile_valid_nr_1w_pkg::*;
#(
    parameter int unsigned WIDTH = REGFILE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic             clr_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Write wins over flush and clear; invalidation leaves data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr_i) begin
            data_q  <= wr_data_i;
            valid_q <= 1'b1;
        end else if (flush_i || clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/regfile_valid_nr_1w.sv
// Parametrised N-read/1-write register file with per-entry valid bits,
// invalidate/flush, registered write-first reads and a live valid count.
module regfile_valid_nr_1w
    import regfile_valid_nr_1w_pkg::*;
#(
    parameter int unsigned DEPTH  = REGFILE_DEPTH,
    parameter int unsigned WIDTH  = REGFILE_WIDTH,
    parameter int unsigned ADDR_W = REGFILE_ADDR_W,
    parameter int unsigned NUM_RD = REGFILE_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic                     flush,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_hit,
    output logic [DEPTH-1:0]         valid_map,
    output logic [ADDR_W:0]          valid_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] wr_dec;
    logic [DEPTH-1:0] clr_dec;

    // Address decoders and entry array; out-of-range addresses decode to nothing.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        assign wr_dec[e]  = wr_en  && (wr_addr  == ADDR_W'(e));
        assign clr_dec[e] = clr_en && (clr_addr == ADDR_W'(e));

        regfile_valid_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .wr_i      (wr_dec[e]),
            .clr_i     (clr_dec[e]),
            .flush_i   (flush),
            .wr_data_i (wr_data),
            .data_o    (ent_data[e]),
            .valid_o   (ent_valid[e])
        );
    end

    assign valid_map = ent_valid;

    // Per-port read path: DEPTH-to-1 mux, write-first bypass, output register.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  mux_data;
        logic              mux_hit;
        logic              byp;
        logic [WIDTH-1:0]  data_q;
        logic              hit_q;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Select the post-update view of the addressed entry.
        always_comb begin
            mux_data = '0;
            mux_hit  = 1'b0;
            byp      = 1'b0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (addr == ADDR_W'(e)) begin
                    mux_data = ent_data[e];
                    mux_hit  = ent_valid[e] && !flush && !clr_dec[e];
                    byp      = wr_dec[e];
                end
            end
            if (byp) begin
                mux_data = wr_data;
                mux_hit  = 1'b1;
            end
        end

        // Load on read strobe, otherwise hold.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                hit_q  <= 1'b0;
            end else if (rd_en[p]) begin
                data_q <= mux_data;
                hit_q  <= mux_hit;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = data_q;
        assign rd_hit[p]                 = hit_q;
    end

    logic [CNT_W-1:0] valid_count_q;
    logic [CNT_W-1:0] valid_count_d;
    logic             wr_new;
    logic             clr_drop;

    // A write only adds when the target was empty; a clear only drops a live
    // entry that is not being rewritten in the same cycle.
    assign wr_new   = |(wr_dec & ~ent_valid);
    assign clr_drop = |(clr_dec & ent_valid & ~wr_dec);

    // Next count: flush reloads, otherwise apply the net delta.
    always_comb begin
        valid_count_d = valid_count_q;
        if (flush) begin
            valid_count_d = CNT_W'(|wr_dec);
        end else begin
            valid_count_d = valid_count_q + CNT_W'(wr_new) - CNT_W'(clr_drop);
        end
    end

    // Valid-count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_count_q <= '0;
        end else begin
            valid_count_q <= valid_count_d;
        end
    end

    assign valid_count = valid_count_q;

    // The incremental counter must always track the valid flops.
    if (DEPTH <= 64) begin : g_chk
        a_count_matches: assert property (@(posedge clk) disable iff (rst)
            32'(valid_count_q) == popcount64(64'(ent_valid)));
        a_count_bound: assert property (@(posedge clk) disable iff (rst)
            32'(valid_count_q) <= DEPTH);
    end

endmodule

// File: tb/tb_regfile_valid_nr_1w.sv
// Scoreboard bench for regfile_valid_nr_1w: directed scenarios plus random traffic
// against an array-based model of the entry contents.
module tb_regfile_valid_nr_1w;

    localparam int unsigned DEPTH  = 40;
    localparam int unsigned WIDTH  = 35;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NUM_RD = 2;

    logic                     clk;
    logic                     rst;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [WIDTH-1:0]         wr_data;
    logic                     clr_en;
    logic [ADDR_W-1:0]        clr_addr;
    logic                     flush;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]  rd_data;
    logic [NUM_RD-1:0]        rd_hit;
    logic [DEPTH-1:0]         valid_map;
    logic [ADDR_W:0]          valid_count;

    regfile_valid_nr_1w #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_en      (clr_en),
        .clr_addr    (clr_addr),
        .flush       (flush),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_hit      (rd_hit),
        .valid_map   (valid_map),
        .valid_count (valid_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int                      tag;
        logic [NUM_RD*WIDTH-1:0] data;
        logic [NUM_RD-1:0]       hit;
        logic [DEPTH-1:0]        map;
        logic [ADDR_W:0]         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Reference model: entry contents, valid bits and held read results.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_vld [DEPTH];
    logic [WIDTH-1:0] m_rd  [NUM_RD];
    bit               m_hit [NUM_RD];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
        end
        for (int p = 0; p < int'(NUM_RD); p++) begin
            m_rd[p]  = '0;
            m_hit[p] = 1'b0;
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        return WIDTH'({$urandom(), $urandom()});
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the expected outputs.
    task automatic cycle(input bit we, input int unsigned wa, input logic [WIDTH-1:0] wd,
                         input bit ce, input int unsigned ca, input bit fl,
                         input logic [NUM_RD-1:0] re, input int unsigned a0, input int unsigned a1);
        int unsigned a [NUM_RD];
        exp_t        e;
        int unsigned cnt;
        wr_en    = we;
        wr_addr  = ADDR_W'(wa);
        wr_data  = wd;
        clr_en   = ce;
        clr_addr = ADDR_W'(ca);
        flush    = fl;
        rd_en    = re;
        rd_addr  = {ADDR_W'(a1), ADDR_W'(a0)};
        a[0] = a0;
        a[1] = a1;
        // State after the edge: invalidations first, then the write overrides.
        if (fl) begin
            for (int i = 0; i < int'(DEPTH); i++) m_vld[i] = 1'b0;
        end
        if (ce && ca < DEPTH) m_vld[ca] = 1'b0;
        if (we && wa < DEPTH) begin
            m_mem[wa] = wd;
            m_vld[wa] = 1'b1;
        end
        // Reads observe the updated state.
        for (int p = 0; p < int'(NUM_RD); p++) begin
            if (re[p]) begin
                if (a[p] < DEPTH) begin
                    m_rd[p]  = m_mem[a[p]];
                    m_hit[p] = m_vld[a[p]];
                end else begin
                    m_rd[p]  = '0;
                    m_hit[p] = 1'b0;
                end
            end
        end
        cnt = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            e.map[i] = m_vld[i];
            cnt += m_vld[i] ? 1 : 0;
        end
        for (int p = 0; p < int'(NUM_RD); p++) begin
            e.data[p*WIDTH +: WIDTH] = m_rd[p];
            e.hit[p]                 = m_hit[p];
        end
        e.cnt = (ADDR_W+1)'(cnt);
        e.tag = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rd_data0"}, 64'(rd_data[0 +: WIDTH]), 64'd0);
        chk({nm, "_rd_data1"}, 64'(rd_data[WIDTH +: WIDTH]), 64'd0);
        chk({nm, "_rd_hit"}, 64'(rd_hit), 64'd0);
        chk({nm, "_valid_count"}, 64'(valid_count), 64'd0);
        chk({nm, "_valid_map"}, 64'(valid_map), 64'd0);
    endtask

    // Monitor: compare registered outputs just after each edge against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
                e = exp_q.pop_front();
                for (int p = 0; p < int'(NUM_RD); p++) begin
                    chk($sformatf("rd_data%0d", p), 64'(rd_data[p*WIDTH +: WIDTH]),
                        64'(e.data[p*WIDTH +: WIDTH]));
                    chk($sformatf("rd_hit%0d", p), 64'(rd_hit[p]), 64'(e.hit[p]));
                end
                chk("valid_map", 64'(valid_map), 64'(e.map));
                chk("valid_count", 64'(valid_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        wr_en = 0; wr_addr = '0; wr_data = '0; clr_en = 0; clr_addr = '0;
        flush = 0; rd_en = '0; rd_addr = '0;
        rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1 check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;

        // Read after reset.
        cycle(0, 0, '0, 0, 0, 0, 2'b11, 0, 39);
        // Write both ends, then read them.
        cycle(1, 39, 35'h7_FFFF_FFFF, 0, 0, 0, 2'b00, 0, 0);
        cycle(1, 0, 35'h1_2345_6789, 0, 0, 0, 2'b00, 0, 0);
        cycle(0, 0, '0, 0, 0, 0, 2'b11, 39, 0);
        // Bypass on port 0 while port 1 holds.
        cycle(1, 5, 35'h0_0000_00AA, 0, 0, 0, 2'b01, 5, 0);
        idle();
        // Clear versus write.
        cycle(1, 39, '0, 1, 39, 1, 2'b00, 0, 0);
        for (int unsigned i = 0; i < 4; i++) cycle(1, i, rnd_data(), 0, 0, 0, 2'b00, 0, 0);
        cycle(1, 2, rnd_data(), 1, 2, 0, 2'b10, 0, 2);
        cycle(0, 0, '0, 1, 3, 0, 2'b01, 3, 0);
        // Fill all, flush with a write, then out-of-range traffic.
        for (int unsigned i = 0; i < DEPTH; i++) cycle(1, i, rnd_data(), 0, 0, 0, 2'b00, 0, 0);
        cycle(1, 10, rnd_data(), 1, 11, 1, 2'b11, 10, 11);
        cycle(1, 45, rnd_data(), 1, 50, 0, 2'b11, 45, 10);
        idle();

        // Mid-operation reset with a write in flight.
        wr_en = 1'b1; wr_addr = ADDR_W'(7); wr_data = rnd_data();
        rd_en = 2'b11; rd_addr = {ADDR_W'(7), ADDR_W'(10)};
        #1 rst = 1'b1;
        #1 check_zero("midreset");
        model_reset();
        exp_q.delete();
        wr_en = 0; rd_en = '0; clr_en = 0; flush = 0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        cycle(0, 0, '0, 0, 0, 0, 2'b11, 7, 7);

        // Random traffic with out-of-range addresses and address collisions.
        for (int n = 0; n < 3000; n++) begin
            int unsigned wa, ca, a0, a1;
            bit we, ce, fl;
            wa = $urandom_range(0, 47);
            ca = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, 47);
            a0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 47);
            a1 = ($urandom_range(0, 3) == 0) ? ca : $urandom_range(0, 47);
            we = ($urandom_range(0, 2) != 0);
            ce = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 63) == 0);
            cycle(we, wa, rnd_data(), ce, ca, fl, NUM_RD'($urandom()), a0, a1);
        end
        idle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
